// File: rtl/mem_burst_sequencer.sv
// mem_burst_sequencer
//    Bus-side front-end for a 255x32 single-port RAM. Accepts one burst
//    command (start word address, length, direction) and turns it into
//    single-word RAM accesses. Write data comes in on a valid/ready stream.
//    Read data goes out on a valid/ready stream through a small skid FIFO
//    that absorbs the RAM's one-cycle read latency and consumer backpressure.
//
// Ports
//    clk, reset_n            : clock, synchronous active-low reset
//    cmd_valid/cmd_ready     : burst command handshake (ready only in IDLE)
//    cmd_write               : 1 = write burst, 0 = read burst
//    cmd_addr, cmd_len       : start byte address (word aligned), length 1..255
//    wr_data/wr_valid/wr_ready : write data stream
//    rd_data/rd_valid/rd_ready : read data stream (FIFO head)
//    busy, done, err         : status; done/err are one-cycle pulses
//    mem_addr, mem_data_in   : RAM byte address and write data
//    mem_write_enable        : RAM write strobe
//    mem_read_enable         : RAM read strobe
//    mem_data_out            : RAM registered read data (one cycle latency)
//    mem_ready               : RAM ready; no strobe is issued while low
module mem_burst_sequencer #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 16,
   parameter int MAX_WORDS  = 255,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic              mem_ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = PTR_W + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [7:0]         r_cur_word;
   logic [7:0]         r_remaining;
   logic               r_inflight;
   logic               r_err;

   logic [DATA_W-1:0]  r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;

   logic [7:0]         w_cmd_word;
   logic [8:0]         w_word_end;
   logic               w_cmd_bad;
   logic               w_cmd_fire;
   logic               w_wr_fire;
   logic               w_pop;
   logic               w_push;
   logic [OCC_W-1:0]   w_occ_after;
   logic               w_issue;

   // ---------------------------------------------------------------
   // Command decode
   // ---------------------------------------------------------------
   assign w_cmd_word = cmd_addr[9:2];
   assign w_word_end = {1'b0, w_cmd_word} + {1'b0, cmd_len};
   assign w_cmd_bad  = (cmd_len == 8'd0)
                     | (cmd_addr[1:0] != 2'b00)
                     | (cmd_addr[ADDR_W-1:10] != '0)
                     | (w_word_end > 9'(MAX_WORDS));
   assign w_cmd_fire = cmd_valid && (r_state == S_IDLE);

   // ---------------------------------------------------------------
   // Access qualification
   // ---------------------------------------------------------------
   assign w_wr_fire = (r_state == S_WRITE) && wr_valid && mem_ready;
   assign w_pop     = (r_count != '0) && rd_ready;
   assign w_push    = r_inflight;

   // A read may only be launched if its data is guaranteed a FIFO slot when
   // it returns next cycle: count what is stored plus what is in flight,
   // minus the entry leaving this cycle.
   assign w_occ_after = OCC_W'(r_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
   assign w_issue     = (r_state == S_READ) && mem_ready
                     && (r_remaining != 8'd0)
                     && (w_occ_after < OCC_W'(FIFO_DEPTH));

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_fire && !w_cmd_bad) begin
               w_state_nxt = cmd_write ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            if (w_wr_fire && (r_remaining == 8'd1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_READ: begin
            if (r_remaining == 8'd0) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!r_inflight && (r_count == '0)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------
   always_comb begin
      cmd_ready        = 1'b0;
      busy             = 1'b1;
      done             = 1'b0;
      wr_ready         = 1'b0;
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
      mem_addr         = '0;
      mem_data_in      = '0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         S_WRITE: begin
            wr_ready         = mem_ready;
            mem_write_enable = w_wr_fire;
            mem_addr         = ADDR_W'({r_cur_word, 2'b00});
            mem_data_in      = wr_data;
         end
         S_READ: begin
            mem_read_enable = w_issue;
            mem_addr        = ADDR_W'({r_cur_word, 2'b00});
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign err      = r_err;
   assign rd_valid = (r_count != '0);
   assign rd_data  = rd_valid ? r_fifo[r_rptr] : '0;

   // ---------------------------------------------------------------
   // Burst counters, inflight flag, error pulse
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cur_word  <= '0;
         r_remaining <= '0;
         r_inflight  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err      <= w_cmd_fire && w_cmd_bad;
         r_inflight <= w_issue;
         if (w_cmd_fire && !w_cmd_bad) begin
            r_cur_word  <= w_cmd_word;
            r_remaining <= cmd_len;
         end else if (w_wr_fire || w_issue) begin
            r_cur_word  <= r_cur_word + 8'd1;
            r_remaining <= r_remaining - 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Read-return skid FIFO
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo[i] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= mem_data_out;
            r_wptr         <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: doc/mem_burst_sequencer.md
Name: mem_burst_sequencer

Overview:
Bus-side front-end for the 255x32 single-port RAM peripheral. It accepts one burst command (start word address, length, direction) and sequences single-word accesses onto the RAM port. Write data arrives on a valid/ready stream. Read data leaves on a valid/ready stream, with a small skid FIFO that absorbs the RAM's one-cycle read latency and consumer backpressure. It sits directly upstream of the RAM and drives its addr/data_in/write_enable/read_enable pins.

Parameters:
DATA_W, 32, data width of RAM and streams
ADDR_W, 16, byte address width toward RAM
MAX_WORDS, 255, RAM depth in words (valid word indices 0..254)
FIFO_DEPTH, 2, read-return skid FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start byte address; must be word-aligned
cmd_len  in  8  burst length in words, 1..255
wr_data  in  DATA_W  write stream data
wr_valid  in  1  write stream valid
wr_ready  out  1  write stream ready
rd_data  out  DATA_W  read stream data, FIFO head
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  read stream consumer ready
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a burst completes
err  out  1  one-cycle pulse when a command is rejected
mem_addr  out  ADDR_W  RAM byte address = word index << 2
mem_data_in  out  DATA_W  RAM write data
mem_write_enable  out  1  RAM write strobe
mem_read_enable  out  1  RAM read strobe
mem_data_out  in  DATA_W  RAM registered read data, valid one cycle after mem_read_enable
mem_ready  in  1  RAM ready; no strobe is issued while low

Behaviour:
- Reset (reset_n=0 at a clk edge, from any state): state=IDLE, counters=0, FIFO emptied, inflight=0. Outputs after reset: cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, err=0, mem_write_enable=0, mem_read_enable=0, mem_addr=0, mem_data_in=0. A burst interrupted by reset is abandoned; no done or err is generated.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: command accepted when cmd_valid && cmd_ready. Let word = cmd_addr[9:2].
  - Reject if cmd_len==0, or cmd_addr[1:0]!=0, or cmd_addr[ADDR_W-1:10]!=0, or word+cmd_len>MAX_WORDS (sum computed 9 bits wide).
  - On reject: err=1 next cycle; stay IDLE; no RAM strobe.
  - Otherwise: load cur_word=word and remaining=cmd_len, then go to WRITE or READ.
- WRITE:
  - wr_ready = mem_ready.
  - On each wr_valid && wr_ready: mem_write_enable=1 in the same cycle (combinational), mem_addr=cur_word<<2, mem_data_in=wr_data. Then cur_word++ and remaining--.
  - After the last handshake (remaining==1): go to DONE.
- READ:
  - issue = mem_ready && remaining>0 && (occupancy + inflight - pop) < FIFO_DEPTH, where pop = rd_valid && rd_ready.
  - mem_read_enable=issue; mem_addr=cur_word<<2; on issue, cur_word++ and remaining--.
  - inflight is a register that takes the value of issue. When inflight=1, mem_data_out is pushed into the FIFO that cycle.
  - When remaining==0: go to DRAIN.
- DRAIN: no strobes. Go to DONE when inflight==0 && FIFO empty.
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 during DONE.
- FIFO: a push and a pop in the same cycle are both honoured (occupancy unchanged). By construction it never overflows. rd_data holds its value while rd_valid && !rd_ready.
- Strobes: mem_write_enable and mem_read_enable are never high together, and never high outside WRITE/READ.
- Throughput: 1 word/cycle in both directions when mem_ready=1, wr_valid=1 and rd_ready=1. First rd_valid appears 2 cycles after the READ state is entered.
- mem_data_out is ignored whenever inflight=0 (the RAM drives 0 there).

Test Plan:
- Write burst cmd_addr=0x0010, len=4, wr_data 0xA0..0xA3 back-to-back -> mem_write_enable for 4 consecutive cycles at mem_addr 0x10,0x14,0x18,0x1C; done one cycle after the last write; busy falls with the return to IDLE.
- Read burst of same region with rd_ready=1 -> mem_read_enable 4 consecutive cycles; rd_data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive rd_valid cycles; done pulses after the FIFO empties.
- Backpressure: read len=8 with rd_ready=0 for the first 6 cycles -> exactly 2 reads issued then stall; no data lost; release yields all 8 words in order.
- Boundaries:
  - cmd_addr=0x03F8, len=1 -> accepted, single access at word 254.
  - cmd_addr=0x03F8, len=2 -> err pulse, no strobe.
  - len=0 -> err.
  - cmd_addr=0x0002 -> err.
- mem_ready held low 3 cycles mid-write -> wr_ready=0 and no strobe while low; burst resumes at the correct address.
- reset_n low during word 3 of an 8-word read -> next cycle all outputs at reset values, FIFO empty, no done; a new command is accepted immediately afterwards.
